// File: rtl/piano_pkg.sv
// Shared constants for the piano tone path: board clock, default counter width
// and half-period values for a few reference notes on the 100 MHz clock.
package piano_pkg;

    localparam int unsigned CLK_FREQ  = 100_000_000;
    localparam int unsigned DEFAULT_N = 25;

    // Half-period in clock cycles for a square wave of tone_hz.
    function automatic int unsigned half_period(input int unsigned clk_hz,
                                                input int unsigned tone_hz);
        return clk_hz / (2 * tone_hz);
    endfunction

    localparam int unsigned HALF_A3 = 227272;
    localparam int unsigned HALF_A4 = 113636;
    localparam int unsigned HALF_A5 = 56818;

endpackage

// File: rtl/multi_tone_divider_channel.sv
// One tone channel: half-period counter, square-wave output and a pending
// half-period register that is only adopted at a toggle boundary.
module multi_tone_divider_channel #(
    parameter int unsigned    N          = 25,
    parameter logic [N-1:0]   RESET_HALF = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] half,
    output logic         clk_out,
    output logic         tick,
    output logic         pend
);

    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] cur_half_q, cur_half_d;
    logic [N-1:0] pend_half_q, pend_half_d;
    logic         pend_valid_q, pend_valid_d;
    logic         out_q, out_d;
    logic         tick_q, tick_d;
    logic         running, terminal, boundary;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave it unassigned and infer a latch.
        running      = en && (cur_half_q != '0);
        terminal     = running && (cnt_q >= cur_half_q - CNT_ONE);
        boundary     = !running || terminal;
        cnt_d        = '0;
        out_d        = out_q;
        tick_d       = 1'b0;
        cur_half_d   = cur_half_q;
        pend_half_d  = pend_half_q;
        pend_valid_d = pend_valid_q;

        if (!running) begin
            out_d = 1'b0;
        end else if (terminal) begin
            out_d  = ~out_q;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        // The boundary consumes the old pending value; a same-cycle load re-arms it.
        if (boundary && pend_valid_q) begin
            cur_half_d   = pend_half_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pend_half_d  = half;
            pend_valid_d = 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            cur_half_q   <= RESET_HALF;
            pend_half_q  <= '0;
            pend_valid_q <= 1'b0;
            out_q        <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            cur_half_q   <= cur_half_d;
            pend_half_q  <= pend_half_d;
            pend_valid_q <= pend_valid_d;
            out_q        <= out_d;
            tick_q       <= tick_d;
        end
    end

    assign clk_out = out_q;
    assign tick    = tick_q;
    assign pend    = pend_valid_q;

endmodule

// File: rtl/multi_tone_divider.sv
// Multi-channel runtime-programmable clock divider: CHANNELS independent
// square-wave generators with glitch-free retuning at toggle boundaries.
module multi_tone_divider
    import piano_pkg::*;
#(
    parameter int unsigned N        = DEFAULT_N,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CLK_Freq = CLK_FREQ,
    parameter int unsigned Out_Freq = 1
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic [CHANNELS-1:0]   EN,
    input  logic [CHANNELS-1:0]   LOAD,
    input  logic [CHANNELS*N-1:0] HALF,
    output logic [CHANNELS-1:0]   CLK_Out,
    output logic [CHANNELS-1:0]   TICK,
    output logic [CHANNELS-1:0]   PEND
);

    localparam logic [N-1:0] DEFAULT_HALF = N'(half_period(CLK_Freq, Out_Freq));

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        multi_tone_divider_channel #(
            .N          (N),
            .RESET_HALF (DEFAULT_HALF)
        ) u_channel (
            .clk     (CLK),
            .rst     (CLR),
            .en      (EN[i]),
            .load    (LOAD[i]),
            .half    (HALF[i*N +: N]),
            .clk_out (CLK_Out[i]),
            .tick    (TICK[i]),
            .pend    (PEND[i])
        );
    end

endmodule

// File: tb/tb_multi_tone_divider.sv
// Self-checking bench for multi_tone_divider: expected TICK edges are queued per
// channel as stimulus is driven and retired by a monitor on the falling edge.
module tb_multi_tone_divider;

    localparam int NW = 25;
    localparam int CH = 4;

    logic             clk = 1'b0;
    logic             clr;
    logic [CH-1:0]    en;
    logic [CH-1:0]    load;
    logic [CH*NW-1:0] half;
    logic [CH-1:0]    clk_out;
    logic [CH-1:0]    tick;
    logic [CH-1:0]    pend;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int exp_q [CH][$];

    multi_tone_divider #(
        .N        (NW),
        .CHANNELS (CH),
        .CLK_Freq (100),
        .Out_Freq (10)
    ) dut (
        .CLK     (clk),
        .CLR     (clr),
        .EN      (en),
        .LOAD    (load),
        .HALF    (half),
        .CLK_Out (clk_out),
        .TICK    (tick),
        .PEND    (pend)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: retire expected tick edges, flag missed and unexpected ticks.
    always @(negedge clk) begin
        int e;
        for (int i = 0; i < CH; i++) begin
            if (exp_q[i].size() != 0 && exp_q[i][0] < cyc) begin
                e = exp_q[i].pop_front();
                vectors++;
                miscompares++;
                $display("FAIL tick_missed ch%0d: no tick at edge %0d (now edge %0d)", i, e, cyc);
            end
            if (tick[i] === 1'b1) begin
                vectors++;
                if (exp_q[i].size() == 0) begin
                    miscompares++;
                    $display("FAIL tick_unexpected ch%0d: tick at edge %0d, none expected", i, cyc);
                end else begin
                    e = exp_q[i].pop_front();
                    if (e != cyc) begin
                        miscompares++;
                        $display("FAIL tick_edge ch%0d: tick at edge %0d, expected edge %0d", i, cyc, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_half(input int ch, input int v);
        half[ch*NW +: NW] = NW'(v);
    endtask

    task automatic push_ticks(input int ch, input int first, input int period, input int last);
        for (int t = first; t <= last; t += period) exp_q[ch].push_back(t);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < CH; i++) begin
            vectors++;
            if (exp_q[i].size() != 0) begin
                miscompares++;
                $display("FAIL %s_leftover ch%0d: %0d expected ticks never seen", name, i, exp_q[i].size());
                exp_q[i].delete();
            end
        end
    endtask

    task automatic test_reset();
        int b;
        clr = 1'b0; en = '0; load = '0; half = '0;
        #2 clr = 1'b1;
        #1;
        vectors++; if (clk_out !== 4'b0000) begin miscompares++; $display("FAIL reset_clk_out: got %b want 0000", clk_out); end
        vectors++; if (tick !== 4'b0000) begin miscompares++; $display("FAIL reset_tick: got %b want 0000", tick); end
        vectors++; if (pend !== 4'b0000) begin miscompares++; $display("FAIL reset_pend: got %b want 0000", pend); end
        en = 4'b0001;
        step(2);
        clr = 1'b0;
        b = cyc;
        push_ticks(0, b + 5, 5, b + 20);
        step(5);
        vectors++; if (clk_out !== 4'b0001) begin miscompares++; $display("FAIL reset_first_toggle: got %b want 0001", clk_out); end
        vectors++; if (pend !== 4'b0000) begin miscompares++; $display("FAIL reset_pend_run: got %b want 0000", pend); end
        step(15);
        vectors++; if (clk_out !== 4'b0000) begin miscompares++; $display("FAIL reset_fourth_toggle: got %b want 0000", clk_out); end
        en = '0;
        step(2);
        vectors++; if (clk_out !== 4'b0000) begin miscompares++; $display("FAIL reset_en_off: got %b want 0000", clk_out); end
        drain("reset");
    endtask

    task automatic test_retune();
        int b;
        en[0] = 1'b1;
        b = cyc;
        exp_q[0].push_back(b + 5);
        push_ticks(0, b + 8, 3, b + 14);
        step(1);
        load[0] = 1'b1; set_half(0, 3);
        step(1);
        load[0] = 1'b0;
        vectors++; if (pend[0] !== 1'b1) begin miscompares++; $display("FAIL retune_pend_set: got %b want 1", pend[0]); end
        step(2);
        vectors++; if (pend[0] !== 1'b1 || clk_out[0] !== 1'b0) begin miscompares++; $display("FAIL retune_hold_old: pend=%b out=%b want pend=1 out=0", pend[0], clk_out[0]); end
        step(1);
        vectors++; if (pend[0] !== 1'b0 || clk_out[0] !== 1'b1) begin miscompares++; $display("FAIL retune_boundary: pend=%b out=%b want pend=0 out=1", pend[0], clk_out[0]); end
        step(9);
        vectors++; if (clk_out[0] !== 1'b0) begin miscompares++; $display("FAIL retune_new_period: got %b want 0", clk_out[0]); end
        en[0] = 1'b0;
        step(2);
        drain("retune");
    endtask

    task automatic test_stopped_apply();
        int b;
        b = cyc;
        load[0] = 1'b1; set_half(0, 2);
        step(1);
        load[0] = 1'b0;
        vectors++; if (pend[0] !== 1'b1) begin miscompares++; $display("FAIL stopped_pend_set: got %b want 1", pend[0]); end
        step(1);
        vectors++; if (pend[0] !== 1'b0) begin miscompares++; $display("FAIL stopped_pend_clear: got %b want 0", pend[0]); end
        en[0] = 1'b1;
        push_ticks(0, b + 4, 2, b + 8);
        step(6);
        vectors++; if (clk_out[0] !== 1'b1) begin miscompares++; $display("FAIL stopped_run: got %b want 1", clk_out[0]); end
        en[0] = 1'b0;
        step(1);
        vectors++; if (clk_out[0] !== 1'b0) begin miscompares++; $display("FAIL stopped_en_fall: got %b want 0", clk_out[0]); end
        drain("stopped");
    endtask

    task automatic test_zero_min();
        int b;
        load[0] = 1'b1; set_half(0, 0);
        step(1);
        load[0] = 1'b0;
        step(1);
        en[0] = 1'b1;
        step(10);
        vectors++; if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin miscompares++; $display("FAIL zero_held: out=%b tick=%b want 0 0", clk_out[0], tick[0]); end
        b = cyc;
        load[0] = 1'b1; set_half(0, 1);
        step(1);
        load[0] = 1'b0;
        push_ticks(0, b + 3, 1, b + 10);
        vectors++; if (pend[0] !== 1'b1) begin miscompares++; $display("FAIL min_pend_set: got %b want 1", pend[0]); end
        step(1);
        vectors++; if (pend[0] !== 1'b0 || clk_out[0] !== 1'b0) begin miscompares++; $display("FAIL min_apply: pend=%b out=%b want 0 0", pend[0], clk_out[0]); end
        step(1);
        vectors++; if (clk_out[0] !== 1'b1) begin miscompares++; $display("FAIL min_first: got %b want 1", clk_out[0]); end
        step(7);
        vectors++; if (clk_out[0] !== 1'b0) begin miscompares++; $display("FAIL min_every_cycle: got %b want 0", clk_out[0]); end
        en[0] = 1'b0;
        step(1);
        drain("zero_min");
    endtask

    task automatic test_simultaneous();
        int b;
        int c;
        load[0] = 1'b1; set_half(0, 5);
        step(1);
        load[0] = 1'b0;
        step(1);
        en[0] = 1'b1;
        b = cyc;
        exp_q[0].push_back(b + 5);
        exp_q[0].push_back(b + 9);
        exp_q[0].push_back(b + 16);
        exp_q[0].push_back(b + 23);
        step(1);
        load[0] = 1'b1; set_half(0, 4);
        step(1);
        load[0] = 1'b0;
        vectors++; if (pend[0] !== 1'b1) begin miscompares++; $display("FAIL simul_pend4: got %b want 1", pend[0]); end
        step(2);
        load[0] = 1'b1; set_half(0, 7);
        step(1);
        load[0] = 1'b0;
        vectors++; if (pend[0] !== 1'b1 || clk_out[0] !== 1'b1) begin miscompares++; $display("FAIL simul_terminal_load: pend=%b out=%b want 1 1", pend[0], clk_out[0]); end
        step(4);
        vectors++; if (pend[0] !== 1'b0 || clk_out[0] !== 1'b0) begin miscompares++; $display("FAIL simul_apply7: pend=%b out=%b want 0 0", pend[0], clk_out[0]); end
        step(14);
        en[0] = 1'b0;
        step(1);
        drain("simul_a");

        en[0] = 1'b1;
        c = cyc;
        exp_q[0].push_back(c + 7);
        exp_q[0].push_back(c + 16);
        exp_q[0].push_back(c + 25);
        step(1);
        load[0] = 1'b1; set_half(0, 6);
        step(1);
        set_half(0, 9);
        step(1);
        load[0] = 1'b0;
        vectors++; if (pend[0] !== 1'b1) begin miscompares++; $display("FAIL simul_double_pend: got %b want 1", pend[0]); end
        step(4);
        vectors++; if (pend[0] !== 1'b0) begin miscompares++; $display("FAIL simul_double_apply: got %b want 0", pend[0]); end
        step(18);
        vectors++; if (clk_out[0] !== 1'b1) begin miscompares++; $display("FAIL simul_last_wins: got %b want 1", clk_out[0]); end
        en[0] = 1'b0;
        step(1);
        drain("simul_b");
    endtask

    task automatic test_reset_isolation();
        int b;
        int r;
        load = 4'b1111;
        set_half(0, 3); set_half(1, 4); set_half(2, 5); set_half(3, 6);
        step(1);
        load = '0;
        step(1);
        en = 4'b1111;
        b = cyc;
        push_ticks(0, b + 3, 3, b + 19);
        push_ticks(1, b + 4, 4, b + 19);
        push_ticks(2, b + 5, 5, b + 5);
        push_ticks(2, b + 14, 5, b + 19);
        push_ticks(3, b + 6, 6, b + 19);
        step(7);
        en[2] = 1'b0;
        step(2);
        vectors++; if (clk_out[2] !== 1'b0) begin miscompares++; $display("FAIL iso_ch2_stopped: got %b want 0", clk_out[2]); end
        en[2] = 1'b1;
        step(8);
        load[3] = 1'b1; set_half(3, 2);
        step(1);
        load[3] = 1'b0;
        step(1);
        vectors++; if (pend !== 4'b1000) begin miscompares++; $display("FAIL iso_pend: got %b want 1000", pend); end
        vectors++; if (clk_out !== 4'b1000) begin miscompares++; $display("FAIL iso_clk_out: got %b want 1000", clk_out); end
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        vectors++; if (clk_out !== 4'b0000 || tick !== 4'b0000 || pend !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrun_clr: out=%b tick=%b pend=%b want all 0", clk_out, tick, pend);
        end
        step(2);
        clr = 1'b0;
        r = cyc;
        for (int i = 0; i < CH; i++) push_ticks(i, r + 5, 5, r + 10);
        step(10);
        vectors++; if (clk_out !== 4'b0000) begin miscompares++; $display("FAIL clr_default_half: got %b want 0000", clk_out); end
        en = '0;
        step(1);
        drain("reset_iso");
    endtask

    initial begin
        test_reset();
        test_retune();
        test_stopped_apply();
        test_zero_min();
        test_simultaneous();
        test_reset_isolation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
